// File: rtl/shift_deserializer.sv
// Serial-to-parallel word assembler: MSB-first (left) or LSB-first (right) shifting,
// with a valid/ready output handshake and one bubble cycle per completed word.
module shift_deserializer #(
  parameter int unsigned W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 dir,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  input  logic                 out_ready,
  output logic [$clog2(W)-1:0] bit_cnt
);

  localparam int unsigned CW = $clog2(W);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] FULL    = 1'b1;

  logic [0:0]   state, state_n;
  logic [W-1:0] sreg, sreg_n;
  logic [W-1:0] shifted;
  logic [W-1:0] data_n;
  logic [CW-1:0] cnt_n;
  logic         dir_latched, dir_n;
  logic         eff_dir;
  logic         valid_n, ready_n;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      sreg        <= '0;
      bit_cnt     <= '0;
      dir_latched <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      in_ready    <= 1'b1;
    end else begin
      state       <= state_n;
      sreg        <= sreg_n;
      bit_cnt     <= cnt_n;
      dir_latched <= dir_n;
      out_valid   <= valid_n;
      out_data    <= data_n;
      in_ready    <= ready_n;
    end
  end

  // First bit of a word shifts with the live dir; later bits use the latched copy
  always_comb begin
    eff_dir = (bit_cnt == '0) ? dir : dir_latched;
    if (eff_dir) begin
      shifted = {in_bit, sreg[W-1:1]};
    end else begin
      shifted = {sreg[W-2:0], in_bit};
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = bit_cnt;
    dir_n   = dir_latched;
    data_n  = out_data;
    valid_n = out_valid;
    ready_n = in_ready;
    case (state)
      COLLECT: begin
        if (clr) begin
          cnt_n  = '0;
          sreg_n = '0;
        end else if (in_valid) begin
          sreg_n = shifted;
          if (bit_cnt == '0) begin
            dir_n = dir;
          end
          if (bit_cnt == CW'(W - 1)) begin
            state_n = FULL;
            cnt_n   = '0;
            data_n  = shifted;
            valid_n = 1'b1;
            ready_n = 1'b0;
          end else begin
            cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      FULL: begin
        // clr is deliberately ignored here so a finished word is never dropped
        if (out_ready) begin
          state_n = COLLECT;
          valid_n = 1'b0;
          ready_n = 1'b1;
        end
      end
      default: begin
        state_n = COLLECT;
        valid_n = 1'b0;
        ready_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed-vector bench for shift_deserializer with W=4 and hand-computed expectations.
module tb_shift_deserializer;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic         in_bit;
  logic         dir;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   bit_cnt;

  int checks;
  int passes;

  shift_deserializer #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .dir       (dir),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .bit_cnt   (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic d);
    in_valid = 1'b1;
    in_bit   = b;
    dir      = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] bits, input logic d);
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i], d);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_cnt"},   32'(bit_cnt),   32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    dir       = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_state("reset");

    // MSB-first word 1,0,1,1
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("left_cnt2", 32'(bit_cnt), 32'd2);
    send_bit(1'b1, 1'b0);
    check("left_no_valid_early", 32'(out_valid), 32'd0);
    send_bit(1'b1, 1'b0);
    check("left_valid", 32'(out_valid), 32'd1);
    check("left_data",  32'(out_data),  32'hB);
    check("left_ready_low", 32'(in_ready), 32'd0);
    step();
    check("left_valid_drop", 32'(out_valid), 32'd0);
    check("left_data_hold",  32'(out_data),  32'hB);

    // LSB-first word 1,0,1,1 -> 1101
    send_word(4'b1011, 1'b1);
    check("right_data", 32'(out_data), 32'hD);
    step();
    // dir toggled after the first bit is ignored
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("dir_toggle_data", 32'(out_data), 32'hD);
    step();

    // Backpressure: 1,1,0,0 held while in_valid stays high
    out_ready = 1'b0;
    send_word(4'b1100, 1'b0);
    check("bp_data", 32'(out_data), 32'hC);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ready", 32'(in_ready),  32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_cnt",   32'(bit_cnt),   32'd0);
      check("bp_hold",  32'(out_data),  32'hC);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release", 32'(out_valid), 32'd0);
    send_word(4'b0110, 1'b0);
    check("bp_next_data", 32'(out_data), 32'h6);
    step();

    // clr after two bits with a concurrent valid bit
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("clr_pre_cnt", 32'(bit_cnt), 32'd2);
    clr = 1'b1;
    send_bit(1'b0, 1'b0);
    clr = 1'b0;
    check("clr_cnt", 32'(bit_cnt), 32'd0);
    send_word(4'b1110, 1'b0);
    check("clr_next_data", 32'(out_data), 32'hE);
    step();

    // rst mid-word with bit_cnt = 3
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("rst_mid_pre_cnt", 32'(bit_cnt), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("rst_mid");

    // rst while FULL
    out_ready = 1'b0;
    send_word(4'b1111, 1'b0);
    check("rst_full_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check_reset_state("rst_full");

    // Gapped LSB-first input 0,0,0,1 -> 1000
    dir = 1'b1;
    send_bit(1'b0, 1'b1);
    step();
    send_bit(1'b0, 1'b1);
    step();
    send_bit(1'b0, 1'b1);
    step();
    check("gap_no_valid", 32'(out_valid), 32'd0);
    check("gap_cnt3", 32'(bit_cnt), 32'd3);
    send_bit(1'b1, 1'b1);
    check("gap_valid", 32'(out_valid), 32'd1);
    check("gap_data",  32'(out_data),  32'h8);
    step();
    check("gap_drop", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
